// File: rtl/ee271_vend_pkg.sv
// Shared vending definitions: item codes, coin encodings and values, FSM states.
package ee271_vend_pkg;

    localparam logic [2:0] ITEM_A = 3'b001;
    localparam logic [2:0] ITEM_B = 3'b010;
    localparam logic [2:0] ITEM_C = 3'b011;
    localparam logic [2:0] ITEM_D = 3'b100;
    localparam logic [2:0] ITEM_E = 3'b101;

    localparam logic [2:0] COIN_NONE = 3'b000;
    localparam logic [2:0] COIN_N    = 3'b001;
    localparam logic [2:0] COIN_D    = 3'b010;
    localparam logic [2:0] COIN_Q    = 3'b100;

    localparam logic [5:0] VAL_N = 6'd5;
    localparam logic [5:0] VAL_D = 6'd10;
    localparam logic [5:0] VAL_Q = 6'd25;

    typedef enum logic [2:0] {IDLE, VEND, PAY, FIN, ERR} state_t;

    function automatic logic [5:0] coin_value(input logic [2:0] coin);
        case (coin)
            COIN_Q:  coin_value = VAL_Q;
            COIN_D:  coin_value = VAL_D;
            COIN_N:  coin_value = VAL_N;
            default: coin_value = 6'd0;
        endcase
    endfunction

endpackage

// File: rtl/change_dispenser_coin_select.sv
// Greedy coin picker: largest coin that fits the remaining amount and is in stock.
module coin_select
    import ee271_vend_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic [5:0]       i_rem,
    input  logic [CNT_W-1:0] i_q,
    input  logic [CNT_W-1:0] i_d,
    input  logic [CNT_W-1:0] i_n,
    output logic [2:0]       o_coin,
    output logic             o_none
);

    always_comb begin
        o_coin = COIN_NONE;
        o_none = 1'b0;
        if (i_rem >= VAL_Q && i_q != '0)
            o_coin = COIN_Q;
        else if (i_rem >= VAL_D && i_d != '0)
            o_coin = COIN_D;
        else if (i_rem >= VAL_N && i_n != '0)
            o_coin = COIN_N;
        else
            o_none = 1'b1;
    end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: hands the item to the hopper, then pays change coin by coin.
module change_dispenser
    import ee271_vend_pkg::*;
#(
    parameter int CNT_W    = 4,
    parameter int INIT_CNT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic [2:0]       item_name,
    input  logic [1:0]       item_amt,
    input  logic [5:0]       change,
    output logic             vend_valid,
    output logic [2:0]       vend_item,
    output logic [1:0]       vend_amt,
    input  logic             vend_ack,
    output logic             coin_valid,
    output logic [2:0]       coin_out,
    input  logic             coin_ack,
    input  logic             refill,
    input  logic [CNT_W-1:0] refill_q,
    input  logic [CNT_W-1:0] refill_d,
    input  logic [CNT_W-1:0] refill_n,
    output logic             busy,
    output logic             done_out,
    output logic             short_flag,
    output logic [5:0]       short_amt,
    input  logic             clear
);

    state_t           r_state;
    logic [5:0]       r_rem;
    logic [CNT_W-1:0] r_q, r_d, r_n;
    logic             r_vend_valid, r_coin_valid, r_busy, r_done, r_short_flag;
    logic [2:0]       r_vend_item, r_coin_out;
    logic [1:0]       r_vend_amt;
    logic [5:0]       r_short_amt;

    logic [5:0]       w_rem_nx;
    logic [CNT_W-1:0] w_q_nx, w_d_nx, w_n_nx;
    logic             w_settle;
    logic [2:0]       w_coin;
    logic             w_none;

    // Next remaining/counter values; the coin picker looks at these so a new
    // coin can be presented on the cycle right after an ack.
    always_comb begin
        w_rem_nx = r_rem;
        w_q_nx   = r_q;
        w_d_nx   = r_d;
        w_n_nx   = r_n;
        w_settle = 1'b0;
        case (r_state)
            IDLE: begin
                if (req) begin
                    w_rem_nx = change;
                    w_settle = (item_amt == 2'd0);
                end else if (refill) begin
                    w_q_nx = refill_q;
                    w_d_nx = refill_d;
                    w_n_nx = refill_n;
                end
            end
            VEND: w_settle = r_vend_valid && vend_ack;
            PAY: begin
                if (r_coin_valid && coin_ack) begin
                    w_settle = 1'b1;
                    w_rem_nx = r_rem - coin_value(r_coin_out);
                    case (r_coin_out)
                        COIN_Q:  w_q_nx = r_q - CNT_W'(1);
                        COIN_D:  w_d_nx = r_d - CNT_W'(1);
                        COIN_N:  w_n_nx = r_n - CNT_W'(1);
                        default: ;
                    endcase
                end
            end
            default: ;
        endcase
    end

    coin_select #(.CNT_W(CNT_W)) u_coin_select (
        .i_rem  (w_rem_nx),
        .i_q    (w_q_nx),
        .i_d    (w_d_nx),
        .i_n    (w_n_nx),
        .o_coin (w_coin),
        .o_none (w_none)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_rem        <= '0;
            r_q          <= CNT_W'(INIT_CNT);
            r_d          <= CNT_W'(INIT_CNT);
            r_n          <= CNT_W'(INIT_CNT);
            r_vend_valid <= 1'b0;
            r_vend_item  <= '0;
            r_vend_amt   <= '0;
            r_coin_valid <= 1'b0;
            r_coin_out   <= COIN_NONE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_short_flag <= 1'b0;
            r_short_amt  <= '0;
        end else begin
            r_rem <= w_rem_nx;
            r_q   <= w_q_nx;
            r_d   <= w_d_nx;
            r_n   <= w_n_nx;
            if (w_settle) begin
                // Item handed over or coin paid: decide what comes next.
                r_busy       <= 1'b1;
                r_vend_valid <= 1'b0;
                if (r_state == IDLE) begin
                    r_vend_item <= item_name;
                    r_vend_amt  <= item_amt;
                end
                if (w_rem_nx == 6'd0) begin
                    r_state      <= FIN;
                    r_done       <= 1'b1;
                    r_coin_valid <= 1'b0;
                    r_coin_out   <= COIN_NONE;
                end else if (w_none) begin
                    r_state      <= ERR;
                    r_short_flag <= 1'b1;
                    r_short_amt  <= w_rem_nx;
                    r_coin_valid <= 1'b0;
                    r_coin_out   <= COIN_NONE;
                end else begin
                    r_state      <= PAY;
                    r_coin_valid <= 1'b1;
                    r_coin_out   <= w_coin;
                end
            end else begin
                case (r_state)
                    IDLE: begin
                        if (req) begin
                            r_state      <= VEND;
                            r_busy       <= 1'b1;
                            r_vend_valid <= 1'b1;
                            r_vend_item  <= item_name;
                            r_vend_amt   <= item_amt;
                        end
                    end
                    FIN: begin
                        r_done  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                    ERR: begin
                        if (clear) begin
                            r_short_flag <= 1'b0;
                            r_short_amt  <= '0;
                            r_busy       <= 1'b0;
                            r_state      <= IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign vend_valid = r_vend_valid;
    assign vend_item  = r_vend_item;
    assign vend_amt   = r_vend_amt;
    assign coin_valid = r_coin_valid;
    assign coin_out   = r_coin_out;
    assign busy       = r_busy;
    assign done_out   = r_done;
    assign short_flag = r_short_flag;
    assign short_amt  = r_short_amt;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: a greedy model predicts the event stream.
module tb_change_dispenser;

    logic       clk = 1'b0;
    logic       rst;
    logic       req, vend_ack, coin_ack, refill, clear;
    logic [2:0] item_name;
    logic [1:0] item_amt;
    logic [5:0] change;
    logic [3:0] refill_q, refill_d, refill_n;
    logic       vend_valid, coin_valid, busy, done_out, short_flag;
    logic [2:0] vend_item, coin_out;
    logic [1:0] vend_amt;
    logic [5:0] short_amt;

    change_dispenser #(.CNT_W(4), .INIT_CNT(15)) dut (
        .clk(clk), .rst(rst), .req(req), .item_name(item_name), .item_amt(item_amt),
        .change(change), .vend_valid(vend_valid), .vend_item(vend_item),
        .vend_amt(vend_amt), .vend_ack(vend_ack), .coin_valid(coin_valid),
        .coin_out(coin_out), .coin_ack(coin_ack), .refill(refill),
        .refill_q(refill_q), .refill_d(refill_d), .refill_n(refill_n),
        .busy(busy), .done_out(done_out), .short_flag(short_flag),
        .short_amt(short_amt), .clear(clear)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int exp_q[$];
    int mq, md, mn;
    int coin_delay = 0;
    bit stray_ack  = 1'b0;

    task automatic check(input string tag, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    endtask

    task automatic sb_event(input int ev);
        if (exp_q.size() == 0) check("unexpected_event", ev, -1);
        else check("event", ev, exp_q.pop_front());
    endtask

    // Event codes: 1000+item*10+amt vend, 2000+coin, 3000 done, 4000+cents short.
    task automatic plan(input int item, input int amt, input int chg, output bit is_short);
        int rem;
        rem = chg;
        is_short = 1'b0;
        if (amt != 0) exp_q.push_back(1000 + item * 10 + amt);
        forever begin
            if (rem == 0) begin exp_q.push_back(3000); break; end
            if (rem >= 25 && mq > 0)      begin exp_q.push_back(2004); rem -= 25; mq--; end
            else if (rem >= 10 && md > 0) begin exp_q.push_back(2002); rem -= 10; md--; end
            else if (rem >= 5 && mn > 0)  begin exp_q.push_back(2001); rem -= 5;  mn--; end
            else begin exp_q.push_back(4000 + rem); is_short = 1'b1; break; end
        end
    endtask

    int cw = 0;
    always @(posedge clk) begin
        #1;
        vend_ack = vend_valid | stray_ack;
        if (!coin_valid) begin
            coin_ack = stray_ack;
            cw = 0;
        end else if (coin_ack) begin
            coin_ack = (coin_delay == 0);
            cw = 0;
        end else if (cw >= coin_delay) begin
            coin_ack = 1'b1;
        end else begin
            cw++;
        end
    end

    logic       prev_cv = 1'b0, prev_ack = 1'b0, prev_short = 1'b0;
    logic [2:0] prev_coin = 3'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_cv = 1'b0; prev_ack = 1'b0; prev_short = 1'b0;
        end else begin
            if (vend_valid && vend_ack) sb_event(1000 + int'(vend_item) * 10 + int'(vend_amt));
            if (coin_valid && coin_ack) sb_event(2000 + int'(coin_out));
            if (done_out) sb_event(3000);
            if (short_flag && !prev_short) sb_event(4000 + int'(short_amt));
            if (coin_valid && prev_cv && !prev_ack) check("coin_stable", coin_out, prev_coin);
            prev_cv = coin_valid; prev_ack = coin_ack; prev_coin = coin_out; prev_short = short_flag;
        end
    end

    task automatic check_counters(input string tag);
        check({tag, "_q"}, dut.r_q, mq);
        check({tag, "_d"}, dut.r_d, md);
        check({tag, "_n"}, dut.r_n, mn);
    endtask

    task automatic do_refill(input int q, input int d, input int n);
        @(posedge clk); #2;
        refill = 1'b1; refill_q = 4'(q); refill_d = 4'(d); refill_n = 4'(n);
        @(posedge clk); #2;
        refill = 1'b0;
        mq = q; md = d; mn = n;
    endtask

    task automatic txn(input int item, input int amt, input int chg, input bit with_refill,
                       input bit poke);
        bit is_short;
        int k;
        plan(item, amt, chg, is_short);
        @(posedge clk); #2;
        item_name = 3'(item); item_amt = 2'(amt); change = 6'(chg); req = 1'b1;
        if (with_refill) begin
            refill = 1'b1; refill_q = 4'd1; refill_d = 4'd1; refill_n = 4'd1;
        end
        @(posedge clk); #2;
        req = 1'b0; refill = 1'b0;
        if (poke) begin
            @(posedge clk); #2;
            item_name = 3'd5; item_amt = 2'd3; change = 6'd63; req = 1'b1;
            @(posedge clk); #2;
            req = 1'b0;
        end
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            @(posedge clk);
            k++;
        end
        if (k >= 200) check("timeout", exp_q.size(), 0);
        @(posedge clk); #2;
        if (is_short) begin
            check("err_busy", busy, 1);
            clear = 1'b1;
            @(posedge clk); #2;
            clear = 1'b0;
            check("short_cleared", short_flag, 0);
        end
        check("idle_busy", busy, 0);
        check_counters("cnt");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req = 1'b0; refill = 1'b0; clear = 1'b0;
        vend_ack = 1'b0; coin_ack = 1'b0;
        item_name = '0; item_amt = '0; change = '0;
        refill_q = '0; refill_d = '0; refill_n = '0;
        mq = 15; md = 15; mn = 15;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_vend_valid", vend_valid, 0);
        check("rst_coin_valid", coin_valid, 0);
        check("rst_short_amt", short_amt, 0);
        check_counters("rst_cnt");
        #1 rst = 1'b0;

        txn(2, 1, 35, 1'b0, 1'b0);          // vend B, quarter, dime -> 14/14/15
        do_refill(0, 15, 15);
        txn(1, 0, 35, 1'b0, 1'b0);          // four coins, no vend
        txn(1, 2, 7, 1'b0, 1'b0);           // nickel then short by 2
        coin_delay = 3;
        txn(3, 0, 10, 1'b0, 1'b1);          // delayed ack, req ignored while busy
        coin_delay = 0;

        @(posedge clk); #2 stray_ack = 1'b1;
        repeat (2) @(posedge clk);
        #2 stray_ack = 1'b0;
        check("stray_busy", busy, 0);
        check_counters("stray_cnt");

        do_refill(15, 15, 15);
        txn(5, 3, 63, 1'b0, 1'b0);          // Q,Q,D then short by 3
        txn(1, 0, 3, 1'b0, 1'b0);           // residual below a nickel
        txn(4, 1, 5, 1'b1, 1'b0);           // req beats refill

        coin_delay = 10;
        @(posedge clk); #2;
        item_name = 3'd1; item_amt = 2'd0; change = 6'd50; req = 1'b1;
        @(posedge clk); #2 req = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_coin_valid", coin_valid, 0);
        check("midrst_coin_out", coin_out, 0);
        check("midrst_busy", busy, 0);
        check("midrst_vend_item", vend_item, 0);
        check("midrst_done", done_out, 0);
        mq = 15; md = 15; mn = 15;
        check_counters("midrst_cnt");
        @(posedge clk); #2 rst = 1'b0;
        coin_delay = 0;
        repeat (3) @(posedge clk);

        txn(2, 0, 0, 1'b0, 1'b0);           // nothing owed: straight to done
        txn(4, 0, 5, 1'b0, 1'b0);           // single nickel

        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameter CNT_W, default 4: width of each coin inventory counter.
REQ-002 Parameter INIT_CNT, default 15: value loaded into every inventory counter at reset.
REQ-003 Port clk, input, 1: single clock; all state updates on posedge clk.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port req, input, 1: one-cycle vend request (the vending FSM's done pulse).
REQ-006 Port item_name, input, 3: item code, A=001 through E=101.
REQ-007 Port item_amt, input, 2: quantity to vend, 0..3.
REQ-008 Port change, input, 6: change owed in cents, 0..63.
REQ-009 Port vend_valid, output, 1: item dispense request to the item hopper.
REQ-010 Port vend_item, output, 3: latched item code.
REQ-011 Port vend_amt, output, 2: latched quantity.
REQ-012 Port vend_ack, input, 1: item hopper accepted the request.
REQ-013 Port coin_valid, output, 1: coin dispense request to the coin hopper.
REQ-014 Port coin_out, output, 3: one-hot coin, 001=nickel, 010=dime, 100=quarter.
REQ-015 Port coin_ack, input, 1: coin hopper released the coin.
REQ-016 Port refill, input, 1: inventory load strobe; honoured in IDLE only.
REQ-017 Port refill_q / refill_d / refill_n, input, CNT_W each: new coin counts.
REQ-018 Port busy, output, 1: high in any state other than IDLE.
REQ-019 Port done_out, output, 1: one-cycle pulse when a transaction completes.
REQ-020 Port short_flag, output, 1: exact change cannot be paid.
REQ-021 Port short_amt, output, 6: cents left unpaid while short_flag is high.
REQ-022 Port clear, input, 1: acknowledges the short condition.

Function
REQ-023 The FSM SHALL have five states: IDLE, VEND, PAY, FIN and ERR.
REQ-024 IDLE: when req=1, the block SHALL latch item_name, item_amt and change (into remaining) and go to VEND. If item_amt=0 it goes to PAY instead. If item_amt=0 and change=0 it goes to FIN.
REQ-025 IDLE: when refill=1 and req=0, the counters SHALL load q/d/n from refill_q/d/n. If refill and req are both high, req wins and refill is ignored.
REQ-026 VEND: vend_valid SHALL be 1, with vend_item and vend_amt held stable until vend_ack. On the vend_ack cycle the FSM goes to PAY, or to FIN if remaining=0.
REQ-027 PAY: the coin SHALL be chosen greedily.
  - quarter if remaining>=25 and q>0;
  - else dime if remaining>=10 and d>0;
  - else nickel if remaining>=5 and n>0;
  - else go to ERR.
REQ-028 PAY: coin_valid SHALL be 1 and coin_out stable until coin_ack. On the coin_ack cycle, remaining decreases by the coin value and that counter decrements by 1. If the new remaining is 0, the FSM goes to FIN; otherwise it stays in PAY. Back-to-back coins SHALL be possible on consecutive cycles.
REQ-029 The coin choice SHALL be re-evaluated only after an ack, never while coin_valid is pending.
REQ-030 FIN: done_out SHALL be 1 for exactly one cycle, then the FSM returns to IDLE.
REQ-031 ERR: short_flag=1 and short_amt=remaining, held until clear=1, then the FSM returns to IDLE with short_flag=0. A residual of 1..4 cents not divisible by 5 SHALL enter ERR.
REQ-032 req, refill and clear SHALL be ignored outside the states that use them. vend_ack and coin_ack SHALL be ignored while the matching valid is low.
REQ-033 Counters SHALL never underflow; a coin with a zero count is never selected.
REQ-034 remaining SHALL be unsigned 6-bit. Subtraction happens only when remaining >= coin value, so no wrap-around occurs.

Reset
REQ-035 On rst=1 the FSM SHALL go to IDLE asynchronously, with q, d and n set to INIT_CNT.
REQ-036 On rst=1, remaining and short_amt SHALL be 0, and every output bit SHALL be 0.
REQ-037 Reset mid-transaction SHALL abandon it: no done_out pulse, and the counters are not preserved.

Structure
REQ-038 Shared package ee271_vend_pkg SHALL hold:
  - item codes A..E;
  - coin one-hot codes and coin values 5, 10, 25;
  - the state enum.
  The vending machine block SHALL use this package too.
REQ-039 Greedy selection SHALL live in combinational sub-module coin_select. Inputs: remaining, q, d, n. Outputs: coin one-hot and a none flag.

Verification
REQ-040 After reset, req with item=B, amt=1, change=35, and acks returned same-cycle: vend B x1, then quarter, then dime, then done_out one cycle later. Counters end at q=14, d=14, n=15.
REQ-041 Refill q=0, d=15, n=15, then change=35, amt=0: dime, dime, dime, nickel, then done_out; no vend_valid.
REQ-042 change=7, amt=2: vend, then nickel, then ERR with short_flag=1 and short_amt=2. clear returns to IDLE with busy=0.
REQ-043 coin_ack delayed 3 cycles: coin_out and coin_valid stay stable for all 4 cycles, and exactly one decrement occurs.
REQ-044 rst asserted mid-PAY with change=50: all outputs go to 0 immediately, counters return to 15, and no done_out occurs.
REQ-045 req asserted while busy, and coin_ack while idle: no state or counter change.
